// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target block.
package spi_target_pkg;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        SHIFT,
        DRAIN
    } state_t;

    localparam int   BITS_PER_BYTE = 8;
    localparam logic MISO_IDLE     = 1'b1;

    // Status word placement, matching the controller's recv_msg[3]/[4] mapping
    localparam int DEF_LO_IDX = 3;
    localparam int DEF_HI_IDX = 4;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with registered history for rise/fall pulses.
module spi_sync_edge #(
    parameter logic IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= IDLE;
            s2 <= IDLE;
            s3 <= IDLE;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign dout = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: returns a snapshotted status word in fixed byte slots
// and hands every received MOSI byte to the local fabric.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int         FRAME_BYTES = 5,
    parameter int         LO_IDX      = DEF_LO_IDX,
    parameter int         HI_IDX      = DEF_HI_IDX,
    parameter logic [7:0] FILL_BYTE   = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    input  logic [15:0] tx_data,
    output logic [7:0]  rx_byte,
    output logic [2:0]  rx_idx,
    output logic        rx_valid,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
);
    state_t      state;
    logic [1:0]  settle;
    logic [15:0] tx_snap;
    logic [2:0]  byte_idx;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_in;
    logic [7:0]  shift_out;
    logic        overrun;

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic [7:0] first_byte, next_byte;
    logic sync_unused;

    spi_sync_edge #(.IDLE(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .din(sclk), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.IDLE(1'b1)) u_cs (
        .clk(clk), .rst(rst), .din(cs_n), .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.IDLE(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .din(mosi), .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign sync_unused = ^{sclk_s, mosi_rise, mosi_fall, shift_out[7]};

    function automatic logic [7:0] slot_byte(input logic [2:0] idx, input logic [15:0] snap);
        if (idx == 3'(LO_IDX)) return snap[7:0];
        if (idx == 3'(HI_IDX)) return snap[15:8];
        return FILL_BYTE;
    endfunction

    assign first_byte = slot_byte(3'd0, tx_data);
    assign next_byte  = slot_byte(byte_idx + 3'd1, tx_snap);

    // Frame FSM; all outputs registered, cs_n rise takes priority over sclk edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SYNC;
            settle     <= 2'd0;
            miso       <= MISO_IDLE;
            rx_byte    <= 8'h00;
            rx_idx     <= 3'd0;
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            tx_snap    <= 16'h0000;
            byte_idx   <= 3'd0;
            bit_cnt    <= 3'd0;
            shift_in   <= 8'h00;
            shift_out  <= 8'h00;
            overrun    <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                // Synchronizers start at idle levels; let them settle before
                // trusting cs_n so a frame already running at reset is skipped
                SYNC: begin
                    if (settle != 2'd3) settle <= settle + 2'd1;
                    else if (cs_s)      state  <= IDLE;
                end
                IDLE: begin
                    miso <= MISO_IDLE;
                    busy <= 1'b0;
                    if (cs_fall) begin
                        tx_snap   <= tx_data;
                        byte_idx  <= 3'd0;
                        bit_cnt   <= 3'd0;
                        shift_out <= first_byte;
                        miso      <= first_byte[7];
                        overrun   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        // Ended before the last byte's final fall: always an error
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        miso      <= MISO_IDLE;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        shift_in <= {shift_in[6:0], mosi_s};
                        if (bit_cnt == 3'(BITS_PER_BYTE - 1)) begin
                            rx_byte  <= {shift_in[6:0], mosi_s};
                            rx_idx   <= byte_idx;
                            rx_valid <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt == 3'(BITS_PER_BYTE - 1)) begin
                            bit_cnt  <= 3'd0;
                            byte_idx <= byte_idx + 3'd1;
                            if (byte_idx == 3'(FRAME_BYTES - 1)) begin
                                miso  <= MISO_IDLE;
                                state <= DRAIN;
                            end else begin
                                shift_out <= next_byte;
                                miso      <= next_byte[7];
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            shift_out <= {shift_out[6:0], 1'b0};
                            miso      <= shift_out[6];
                        end
                    end
                end
                DRAIN: begin
                    miso <= MISO_IDLE;
                    if (cs_rise) begin
                        if (overrun) frame_err  <= 1'b1;
                        else         frame_done <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (sclk_rise) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Randomized bench for spi_target: acts as the SPI controller and checks
// MISO bytes, rx events and frame outcome against a frame-level model.
module tb_spi_target;
    localparam int FB = 5;
    localparam int H  = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic [15:0] tx_data = 16'h0000;
    logic        miso;
    logic [7:0]  rx_byte;
    logic [2:0]  rx_idx;
    logic        rx_valid, frame_done, frame_err, busy;

    always #5 clk = ~clk;

    spi_target dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .rx_byte(rx_byte), .rx_idx(rx_idx), .rx_valid(rx_valid),
        .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    int checks = 0;
    int failures = 0;
    int out_seen = 0;
    int rx_cnt = 0;
    logic [10:0] exp_q[$];
    logic [1:0]  exp_out = 2'b00;   // {done, err} expected at frame end
    logic [7:0]  mosi_tab[8];
    logic [7:0]  got_tab[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Model: slot contents seen by the controller for byte i of a frame
    function automatic logic [7:0] model_byte(input int i, input logic [15:0] snap);
        if (i >= FB) return 8'hFF;
        if (i == 3)  return snap[7:0];
        if (i == 4)  return snap[15:8];
        return 8'h00;
    endfunction

    // Compare process: every rx event and frame outcome pulse
    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected actual=%h required=none", {rx_idx, rx_byte});
                end else begin
                    chk("rx_event", {21'd0, rx_idx, rx_byte}, {21'd0, exp_q.pop_front()});
                end
            end
            if (frame_done || frame_err) begin
                out_seen++;
                chk("outcome", {30'd0, frame_done, frame_err}, {30'd0, exp_out});
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_miso"}, miso, 1);
        chk({tag, "_rx_byte"}, rx_byte, 0);
        chk({tag, "_rx_idx"}, rx_idx, 0);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_frame(input int nbytes, input int extra, input logic [15:0] tx,
                             input bit chg, input logic [15:0] tx2,
                             input int rst_byte, input int rst_bit);
        logic [15:0] snap;
        logic [7:0]  got;
        bit          reset_done;
        int          seen0, nb_total, nbits;
        snap = tx;
        reset_done = 0;
        got = 8'h00;
        seen0 = out_seen;
        tx_data = tx;
        wclk(4);
        exp_out = (nbytes == FB && extra == 0) ? 2'b10 : 2'b01;
        cs_n = 1'b0;
        nb_total = nbytes + ((extra > 0) ? 1 : 0);
        for (int i = 0; i < nb_total; i++) begin
            nbits = (i < nbytes) ? 8 : extra;
            for (int b = 0; b < nbits; b++) begin
                if (i == rst_byte && b == rst_bit) begin
                    rst = 1'b0;
                    #1;
                    check_reset_vals("midrst");
                    wclk(3);
                    rst = 1'b1;
                    reset_done = 1;
                    exp_out = 2'b00;
                end
                mosi = mosi_tab[i][7-b];
                wclk(H);
                if (i == 0 && b == 0) chk("busy_in_frame", busy, 1);
                got[7-b] = miso;
                sclk = 1'b1;
                if (b == 7 && i < FB && !reset_done) exp_q.push_back({3'(i), mosi_tab[i]});
                wclk(H);
                sclk = 1'b0;
            end
            if (nbits == 8) begin
                got_tab[i] = got;
                if (!reset_done) chk($sformatf("miso_byte%0d", i), got, model_byte(i, snap));
            end
            if (i == 1 && chg) tx_data = tx2;
        end
        wclk(H);
        cs_n = 1'b1;
        wclk(12);
        chk("rx_drained", exp_q.size(), 0);
        exp_q.delete();
        if (exp_out != 2'b00) chk("outcome_seen", out_seen - seen0, 1);
        else                  chk("no_outcome", out_seen - seen0, 0);
        chk("idle_busy", busy, 0);
        chk("idle_miso", miso, 1);
        exp_out = 2'b00;
    endtask

    task automatic fill_tab(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
        mosi_tab[0] = b0; mosi_tab[1] = b1; mosi_tab[2] = b2; mosi_tab[3] = b3; mosi_tab[4] = b4;
        mosi_tab[5] = 8'h5A; mosi_tab[6] = 8'hC3; mosi_tab[7] = 8'h0F;
    endtask

    initial begin
        int rx0, nb, ex;
        #20;
        check_reset_vals("reset");
        rst = 1'b1;
        wclk(8);

        // Basic frame with literal expectations
        fill_tab(8'h01, 8'h42, 8'h00, 8'h00, 8'h00);
        run_frame(5, 0, 16'hAA55, 0, 16'h0, -1, -1);
        chk("lit_b0", got_tab[0], 8'h00);
        chk("lit_b2", got_tab[2], 8'h00);
        chk("lit_lo", got_tab[3], 8'h55);
        chk("lit_hi", got_tab[4], 8'hAA);
        chk("lit_rx_count", rx_cnt, 5);

        // tx_data change mid-frame only affects the next frame
        fill_tab(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        run_frame(5, 0, 16'hAA55, 1, 16'h1234, -1, -1);
        chk("chg_lo", got_tab[3], 8'h55);
        chk("chg_hi", got_tab[4], 8'hAA);
        run_frame(5, 0, 16'h1234, 0, 16'h0, -1, -1);
        chk("next_lo", got_tab[3], 8'h34);
        chk("next_hi", got_tab[4], 8'h12);

        // Abort after 3 bits of byte 2
        rx0 = rx_cnt;
        run_frame(2, 3, 16'hAA55, 0, 16'h0, -1, -1);
        chk("abort_rx_count", rx_cnt - rx0, 2);

        // Overlong frame
        rx0 = rx_cnt;
        fill_tab(8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h99);
        run_frame(7, 0, 16'hAA55, 0, 16'h0, -1, -1);
        chk("long_b5", got_tab[5], 8'hFF);
        chk("long_b6", got_tab[6], 8'hFF);
        chk("long_rx_count", rx_cnt - rx0, 5);

        // Zero sclk edges
        run_frame(0, 0, 16'hAA55, 0, 16'h0, -1, -1);

        // Reset mid byte 3 with cs_n held low, then a normal frame
        run_frame(5, 0, 16'hAA55, 0, 16'h0, 3, 4);
        run_frame(5, 0, 16'hAA55, 0, 16'h0, -1, -1);
        chk("post_rst_lo", got_tab[3], 8'h55);
        chk("post_rst_hi", got_tab[4], 8'hAA);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 8; k++) mosi_tab[k] = 8'($urandom);
            nb = ($urandom_range(0, 1) == 0) ? FB : $urandom_range(0, 7);
            ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            run_frame(nb, ex, 16'($urandom), $urandom_range(0, 1) == 1, 16'($urandom), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- Synthesizable SPI peripheral (target) that answers the existing SPI controller from the far side of the MISO/MOSI link.
- Mode 0, MSB first, fixed-length frames of FRAME_BYTES bytes.
- Drives a 16-bit status word on byte slots 3 (low byte) and 4 (high byte), so the controller's read returns {16'b0, hi, lo}.
- Captures every MOSI byte for the local fabric. Used as the on-board responder and as the bench model for CPU lw-from-SPI checks.

Parameters:
- FRAME_BYTES, 5, bytes per frame; byte index runs 0..FRAME_BYTES-1.
- LO_IDX, 3, byte slot carrying tx_data[7:0].
- HI_IDX, 4, byte slot carrying tx_data[15:8].
- FILL_BYTE, 8'h00, value sent in every other in-frame slot.

Ports:
- clk  in  1  system clock; sclk half-period must be >= 4 clk.
- rst  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from the controller; asynchronous to clk.
- cs_n  in  1  chip select, active low; asynchronous.
- mosi  in  1  controller-to-target data; asynchronous.
- miso  out  1  target-to-controller data.
- tx_data  in  16  status word; snapshotted at frame start.
- rx_byte  out  8  last complete MOSI byte.
- rx_idx  out  3  byte index of rx_byte.
- rx_valid  out  1  one-clk pulse when rx_byte/rx_idx update.
- frame_done  out  1  one-clk pulse on a clean frame end.
- frame_err  out  1  one-clk pulse on an aborted or overlong frame.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset values: miso=1, rx_byte=0, rx_idx=0, rx_valid=0, frame_done=0, frame_err=0, busy=0, state=SYNC.
- Input conditioning: sclk, cs_n and mosi each pass a 2-flop synchronizer. Edge detect on the synchronized sclk and cs_n.
- Latency: any pin change is acted on 3 clk after the pin changes.
- States:
  - SYNC: entered after reset. Wait until synchronized cs_n=1, then go to IDLE. A frame in progress at reset is ignored entirely.
  - IDLE: miso=1. On cs_n fall: tx_snap<=tx_data, byte_idx<=0, bit_cnt<=0, load shift_out with the slot byte for index 0, drive miso=shift_out[7], busy=1, go to SHIFT.
  - SHIFT:
    - sclk rise: shift_in<={shift_in[6:0], mosi_sync}.
    - sclk fall: bit_cnt++ and shift shift_out left; miso=next MSB.
    - After the 8th rise: rx_byte<=assembled byte, rx_idx<=byte_idx, rx_valid pulse.
    - On the 8th fall: bit_cnt<=0 and byte_idx++. Load the next slot byte, or go to DRAIN if byte_idx reaches FRAME_BYTES.
  - DRAIN: miso=1, sclk edges ignored, no rx_valid. Any sclk rise here flags an overrun, reported at frame end.
- Slot byte selection: LO_IDX -> tx_snap[7:0]; HI_IDX -> tx_snap[15:8]; all others -> FILL_BYTE. tx_data changes mid-frame have no effect.
- Frame end (cs_n rise, any state except SYNC/IDLE):
  - Clean frame: exactly FRAME_BYTES complete bytes and no overrun. Pulse frame_done.
  - Any other case: partial byte, fewer bytes, or overrun. Pulse frame_err, with no rx_valid for the partial byte.
  - Then busy=0, miso=1, go to IDLE.
- Simultaneous cs_n rise and sclk edge in the same clk: cs_n wins and the edge is discarded.
- A cs_n fall and rise within one synchronizer window is ignored. A frame with zero sclk edges produces frame_err.
- Reset mid-frame (async): all outputs return to reset values immediately, and the block goes to SYNC.
- Timing constraint: cs_n fall to first sclk rise must be >= 4 clk, so MSB is valid before the controller samples it.

Decomposition:
- Shared package spi_target_pkg:
  - state enum {SYNC, IDLE, SHIFT, DRAIN};
  - BITS_PER_BYTE=8; idle MISO level constant;
  - default slot indices, matching the controller's recv_msg[3]/[4] mapping.
- One sub-module, spi_sync_edge: 2-flop synchronizer plus rise/fall pulse outputs, with async active-low reset to a parameterised idle level. Instantiated for sclk (idle 0), cs_n (idle 1) and mosi (idle 0).

Test Plan:
- tx_data=16'hAA55; controller runs a 5-byte frame, MOSI=8'h01,8'h42,0,0,0 -> controller sees 00,00,00,55,AA. rx_valid fires 5 times with (0,01),(1,42),(2,00),(3,00),(4,00). One frame_done, no frame_err.
- End-to-end with the CPU: lw from 32'h00030000 -> x5 == 32'h0000AA55.
- tx_data changes 16'hAA55->16'h1234 between bytes 1 and 2 -> this frame still returns 55/AA; the next frame returns 34/12.
- cs_n deasserted after 3 bits of byte 2 -> rx_valid only for idx 0,1; frame_err=1, frame_done=0, miso=1 within 3 clk.
- 7-byte frame -> bytes 5,6 read 8'hFF, only 5 rx_valid pulses, frame_err at cs_n rise.
- rst asserted mid byte 3 with cs_n held low, released, frame continues -> no rx_valid/frame_done until cs_n goes high; the next full frame returns 55/AA correctly.
